// File: rtl/ddr_ctrl_pkg.sv
// ddr_ctrl_pkg
//   Shared constants for the DDR read-side buffer: default data geometry,
//   burst size, frame size and the one-hot states of the credit FSM.
//   No ports.
package ddr_ctrl_pkg;
   localparam int DATA_W      = 256;
   localparam int PIX_W       = 32;
   localparam int DEPTH       = 256;
   localparam int BURST_LEN   = 64;
   localparam int FRAME_BEATS = 98304;

   // Credit FSM states, one-hot.
   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_ISSUE = 3'b010;
   localparam logic [2:0] ST_WAIT  = 3'b100;
endpackage

// File: rtl/ddr_rd_buf_fifo.sv
// ddr_rd_buf_fifo
//   Synchronous FIFO of W-bit words, DEPTH entries (power of 2), block-RAM
//   style storage with a registered read port. The read register only updates
//   on a pop, so it doubles as the holding register for the word being
//   consumed downstream.
// Ports
//   ui_clk    in   clock
//   rst       in   sync reset, active-high (pointers, count, overflow, rd_data)
//   wr_en     in   write request; dropped when full unless a pop frees a slot
//   wr_data   in   W-bit write word
//   rd_en     in   pop request; ignored when empty
//   rd_data   out  W-bit word popped on the previous accepted rd_en
//   count     out  registered number of stored words, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
//   overflow  out  sticky; a write was dropped because the FIFO was full
module ddr_rd_buf_fifo #(
   parameter int W     = 256,
   parameter int DEPTH = 256
) (
   input  logic                         ui_clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [W-1:0]                 wr_data,
   input  logic                         rd_en,
   output logic [W-1:0]                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;
   logic          push;
   logic          pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign pop   = rd_en & ~empty;
   // A write while full still succeeds when the same edge pops a word; the
   // read register captures the old contents of that slot first.
   assign push  = wr_en & (~full | pop);

   always_ff @(posedge ui_clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (pop) begin
         rd_data <= mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + CW'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - CW'(1);
         end
         if (wr_en && !push) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign count    = count_reg;
   assign overflow = overflow_reg;
endmodule

// File: rtl/ddr_rd_buf.sv
// ddr_rd_buf
//   Read-side buffer behind the DDR read controller. Requests BURST_LEN-beat
//   bursts whenever the FIFO has room for a whole burst on top of everything
//   already stored or still in flight, buffers returned beats, and unpacks
//   each beat into PIX_W-bit pixels (lowest word first) on a valid/ready
//   stream with start-of-frame marking.
// Optional build macro
//   DDR_RD_BUF_STATS_EN : adds underrun_cnt, a saturating count of cycles in
//                         which the consumer was ready but no pixel was valid
//                         while requests were enabled.
// Ports
//   ui_clk          in   clock
//   rst             in   sync reset, active-high
//   enable          in   allow new burst requests
//   rd_start        out  one-cycle burst request pulse
//   rd_busy         in   read controller issuing commands (informational)
//   rd_done         in   last command of the open burst accepted
//   rd_ddr_data_vld in   returned beat valid (cannot be stalled)
//   rd_ddr_data     in   returned beat
//   pix_valid       out  pixel valid
//   pix_data        out  pixel
//   pix_sof         out  first pixel of a frame
//   pix_ready       in   consumer ready
//   fifo_level      out  beats stored in the FIFO
//   underrun_cnt    out  (DDR_RD_BUF_STATS_EN only) underrun cycle count
//   overflow        out  sticky, beat dropped on a full FIFO
module ddr_rd_buf #(
   parameter int DATA_W      = ddr_ctrl_pkg::DATA_W,
   parameter int PIX_W       = ddr_ctrl_pkg::PIX_W,
   parameter int DEPTH       = ddr_ctrl_pkg::DEPTH,
   parameter int BURST_LEN   = ddr_ctrl_pkg::BURST_LEN,
   parameter int FRAME_BEATS = ddr_ctrl_pkg::FRAME_BEATS
) (
   input  logic                         ui_clk,
   input  logic                         rst,
   input  logic                         enable,
   output logic                         rd_start,
   input  logic                         rd_busy,
   input  logic                         rd_done,
   input  logic                         rd_ddr_data_vld,
   input  logic [DATA_W-1:0]            rd_ddr_data,
   output logic                         pix_valid,
   output logic [PIX_W-1:0]             pix_data,
   output logic                         pix_sof,
   input  logic                         pix_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
`ifdef DDR_RD_BUF_STATS_EN
   output logic [31:0]                  underrun_cnt,
`endif
   output logic                         overflow
);
   import ddr_ctrl_pkg::ST_IDLE, ddr_ctrl_pkg::ST_ISSUE, ddr_ctrl_pkg::ST_WAIT;

   localparam int PIX_PER_BEAT = DATA_W / PIX_W;
   localparam int IW = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int SW = LW + 1;
   localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

   logic [2:0]        state_reg;
   logic [2:0]        state_next;
   logic [LW-1:0]     outstanding_reg;
   logic [LW-1:0]     outstanding_next;
   logic [LW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [SW-1:0]     committed;
   logic              credit_ok;
   logic [DATA_W-1:0] beat;
   logic              load;
   logic              accept;
   logic              last_pix;
   logic              pix_valid_reg;
   logic [IW-1:0]     pix_idx_reg;
   logic [BW-1:0]     beat_cnt_reg;
   logic              unused_inputs;

   assign unused_inputs = ^{rd_busy, fifo_full};

   // ---------------- credit FSM ----------------
   // Room must exist for a full burst beyond what is stored plus what has
   // been requested but not yet returned.
   assign committed = SW'(fifo_count) + SW'(outstanding_reg);
   assign credit_ok = (committed <= SW'(DEPTH - BURST_LEN));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (enable && credit_ok) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT:  if (rd_done) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   assign rd_start = (state_reg == ST_ISSUE);

   always_comb begin
      outstanding_next = outstanding_reg;
      if (rd_start) begin
         outstanding_next = outstanding_next + LW'(BURST_LEN);
      end
      // A beat nobody asked for is not allowed to wrap the credit below zero.
      if (rd_ddr_data_vld && outstanding_next != '0) begin
         outstanding_next = outstanding_next - LW'(1);
      end
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         outstanding_reg <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
      end
   end

   // ---------------- beat storage ----------------
   // The FIFO read register holds the beat being unpacked; it is refreshed
   // only when a new beat is loaded.
   ddr_rd_buf_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ui_clk   (ui_clk),
      .rst      (rst),
      .wr_en    (rd_ddr_data_vld),
      .wr_data  (rd_ddr_data),
      .rd_en    (load),
      .rd_data  (beat),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (overflow)
   );

   assign fifo_level = fifo_count;

   // ---------------- unpacker ----------------
   assign last_pix = (pix_idx_reg == IW'(PIX_PER_BEAT - 1));
   assign accept   = pix_valid_reg & pix_ready;
   // Load into an empty holder, or back-to-back as the last pixel leaves.
   assign load     = ~fifo_empty & (~pix_valid_reg | (accept & last_pix));

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         pix_valid_reg <= 1'b0;
         pix_idx_reg   <= '0;
      end else if (load) begin
         pix_valid_reg <= 1'b1;
         pix_idx_reg   <= '0;
      end else if (accept) begin
         if (last_pix) begin
            pix_valid_reg <= 1'b0;
            pix_idx_reg   <= '0;
         end else begin
            pix_idx_reg   <= pix_idx_reg + IW'(1);
         end
      end
   end

   logic [PIX_W-1:0] pix_word [PIX_PER_BEAT];
   for (genvar gi = 0; gi < PIX_PER_BEAT; gi++) begin : g_pix
      assign pix_word[gi] = beat[gi*PIX_W +: PIX_W];
   end

   assign pix_valid = pix_valid_reg;
   assign pix_data  = pix_word[pix_idx_reg];

   // beat_cnt_reg is the frame position of the beat currently held, so it
   // advances when that beat's last pixel is consumed.
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         beat_cnt_reg <= '0;
      end else if (accept && last_pix) begin
         if (beat_cnt_reg == BW'(FRAME_BEATS - 1)) begin
            beat_cnt_reg <= '0;
         end else begin
            beat_cnt_reg <= beat_cnt_reg + BW'(1);
         end
      end
   end

   assign pix_sof = pix_valid_reg & (beat_cnt_reg == '0) & (pix_idx_reg == '0);

`ifdef DDR_RD_BUF_STATS_EN
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         underrun_cnt <= '0;
      end else if (enable && pix_ready && !pix_valid_reg && underrun_cnt != '1) begin
         underrun_cnt <= underrun_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ddr_rd_buf.sv
`timescale 1ns/1ps
module tb_ddr_rd_buf;
   localparam int DATA_W      = 256;
   localparam int PIX_W       = 32;
   localparam int DEPTH       = 256;
   localparam int BURST_LEN   = 64;
   localparam int FRAME_BEATS = 4;   // short frame so wrap-around is reachable
   localparam int PPB         = DATA_W / PIX_W;

   logic              ui_clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic              rd_busy = 1'b0;
   logic              rd_done = 1'b0;
   logic              rd_ddr_data_vld = 1'b0;
   logic [DATA_W-1:0] rd_ddr_data = '0;
   logic              pix_ready = 1'b0;
   logic              rd_start;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_sof;
   logic [8:0]        fifo_level;
   logic              overflow;
`ifdef DDR_RD_BUF_STATS_EN
   logic [31:0]       underrun_cnt;
`endif

   always #5 ui_clk = ~ui_clk;

   ddr_rd_buf #(
      .DATA_W      (DATA_W),
      .PIX_W       (PIX_W),
      .DEPTH       (DEPTH),
      .BURST_LEN   (BURST_LEN),
      .FRAME_BEATS (FRAME_BEATS)
   ) dut (
      .ui_clk          (ui_clk),
      .rst             (rst),
      .enable          (enable),
      .rd_start        (rd_start),
      .rd_busy         (rd_busy),
      .rd_done         (rd_done),
      .rd_ddr_data_vld (rd_ddr_data_vld),
      .rd_ddr_data     (rd_ddr_data),
      .pix_valid       (pix_valid),
      .pix_data        (pix_data),
      .pix_sof         (pix_sof),
      .pix_ready       (pix_ready),
      .fifo_level      (fifo_level),
`ifdef DDR_RD_BUF_STATS_EN
      .underrun_cnt    (underrun_cnt),
`endif
      .overflow        (overflow)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Pixel k of beat b carries a unique, recognisable value.
   function automatic logic [31:0] word(input int b, input int k);
      return 32'hA000_0000 + 32'(b << 8) + 32'(k);
   endfunction

   function automatic logic [DATA_W-1:0] make_beat(input int b);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < PPB; k++) v[k*PIX_W +: PIX_W] = word(b, k);
      return v;
   endfunction

   // ---------------- model state ----------------
   int                cyc = 0;
   logic [DATA_W-1:0] m_data [$];   // beats written, not yet fully consumed
   int                m_wc   [$];   // cycle in which each beat was presented
   int                hb_abs;       // frame-relative index of the head beat
   int                hp;           // next pixel of the head beat
   int                beat_no;      // next beat number to return
   int                owed;         // beats requested but not yet returned
   int                done_cnt;
   int                starts = 0;
   int                coincide = 0;
   int                sof_seen = 0;
   bit                open_req;
   longint            exp_under;
   logic [DATA_W-1:0] fb;
   bit                ev;
   int                cap;
   int                lvl;

   always @(posedge ui_clk) cyc <= cyc + 1;

   // Per-cycle compare plus read-controller responder, at the falling edge.
   initial begin
      forever begin
         @(negedge ui_clk);
         if (rst) begin
            m_data.delete();
            m_wc.delete();
            hb_abs = 0; hp = 0; beat_no = 0; owed = 0; done_cnt = 0;
            open_req = 0; exp_under = 0;
            rd_ddr_data_vld = 0; rd_done = 0; rd_busy = 0;
         end else begin
            // A beat presented in cycle N is visible as a pixel from N+2 on.
            ev = (m_data.size() > 0) && (hp > 0 || m_wc[0] <= cyc - 2);
            cap = 0;
            for (int i = 0; i < m_data.size(); i++) if (m_wc[i] < cyc) cap++;
            lvl = cap - (ev ? 1 : 0);

            check("pix_valid", pix_valid, ev);
            if (ev) begin
               fb = m_data[0];
               check("pix_data", pix_data, fb[hp*PIX_W +: PIX_W]);
               check("pix_sof", pix_sof, ((hb_abs % FRAME_BEATS) == 0) && hp == 0);
            end else begin
               check("pix_sof_idle", pix_sof, 0);
            end
            check("fifo_level", fifo_level, lvl);
            check("overflow", overflow, 0);
`ifdef DDR_RD_BUF_STATS_EN
            check("underrun_cnt", underrun_cnt, exp_under);
            if (enable && pix_ready && !ev) exp_under++;
`endif
            if (ev && pix_ready) begin
               if (pix_sof) sof_seen++;
               hp++;
               if (hp == PPB) begin
                  hp = 0;
                  hb_abs++;
                  void'(m_data.pop_front());
                  void'(m_wc.pop_front());
               end
            end

            if (rd_start) begin
               check("one_open_request", open_req, 0);
               check("credit_limit", (owed + lvl <= DEPTH - BURST_LEN), 1);
               if (owed > 0) coincide++;
               open_req = 1;
               owed += BURST_LEN;
               done_cnt = 3;
               starts++;
            end
            rd_done = 0;
            if (done_cnt > 0) begin
               done_cnt--;
               if (done_cnt == 0) begin
                  rd_done = 1;
                  open_req = 0;
               end
            end
            rd_busy = (done_cnt > 0);
            if (owed > 0) begin
               rd_ddr_data = make_beat(beat_no);
               rd_ddr_data_vld = 1;
               m_data.push_back(make_beat(beat_no));
               m_wc.push_back(cyc);
               beat_no++;
               owed--;
            end else begin
               rd_ddr_data_vld = 0;
            end
         end
      end
   end

   initial begin
      #600us;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge ui_clk);
      #2;
   endtask

   initial begin
      int k;
      int n;
      int s0;
      rst = 1;
      repeat (4) @(posedge ui_clk);
      #2;
      check("reset_rd_start", rd_start, 0);
      check("reset_pix_valid", pix_valid, 0);
      check("reset_fifo_level", fifo_level, 0);
      check("reset_overflow", overflow, 0);
      check("reset_pix_sof", pix_sof, 0);
      check("reset_pix_data", pix_data, 0);

      // Request latency after enable on an empty FIFO
      rst = 0; enable = 1; pix_ready = 1;
      k = 0;
      while (!rd_start && k < 8) begin step(); k++; end
      check("t1_rd_start_latency", (rd_start && k >= 1 && k <= 2), 1);
      enable = 0;

      // One burst streamed out: 512 pixels without gaps
      k = 0;
      while (!pix_valid && k < 50) begin step(); k++; end
      check("t2_first_pixel", pix_data, 32'hA000_0000);
      check("t2_first_sof", pix_sof, 1);
      n = 0;
      while (pix_valid && n < 600) begin n++; step(); end
      check("t2_gapless_pixels", n, 512);
      check("t2_level_empty", fifo_level, 0);
      check("t2_sof_count", sof_seen, 16);

      // Consumer stalled: credit stops at four bursts
      s0 = starts;
      pix_ready = 0; enable = 1;
      repeat (400) step();
      check("t3_bursts", starts - s0, 4);
      // 256 beats buffered: one held in the unpack register, 255 in the FIFO
      check("t3_fifo_level", fifo_level, 255);
      check("t3_holding", pix_valid, 1);
      check("t3_held_pixel", pix_data, 32'hA000_4000);
      check("t3_overflow", overflow, 0);
      check("t3_start_with_beat", coincide > 0, 1);

      // Drain with requests disabled
      enable = 0; pix_ready = 1;
      k = 0;
      while ((pix_valid || fifo_level != 0) && k < 3000) begin step(); k++; end
      check("drain_done", (pix_valid == 0 && fifo_level == 0), 1);
      check("t5_sof_count", sof_seen, 80);

      // Reset mid-burst with 100 beats stored
      enable = 1; pix_ready = 0;
      k = 0;
      while (fifo_level != 100 && k < 600) begin step(); k++; end
      check("t6_level_reached", fifo_level, 100);
      rst = 1;
      step();
      check("t6_level_after_rst", fifo_level, 0);
      check("t6_valid_after_rst", pix_valid, 0);
      check("t6_idle_after_rst", rd_start, 0);
`ifdef DDR_RD_BUF_STATS_EN
      check("t6_underrun_cleared", underrun_cnt, 0);
`endif
      rst = 0; pix_ready = 1;
      k = 0;
      while (!pix_valid && k < 50) begin step(); k++; end
      check("t6_sof_after_rst", pix_sof, 1);
      check("t6_first_pixel", pix_data, 32'hA000_0000);
      enable = 0;
      k = 0;
      while ((pix_valid || fifo_level != 0) && k < 3000) begin step(); k++; end
      check("t6_drain_done", (pix_valid == 0 && fifo_level == 0), 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
